// File: rtl/mem_arbiter.sv
// Round-robin arbiter that shares one table-memory port among NUM_REQ requesters.
// Optional BUSY watchdog is enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_ce_i,
  input  logic [NUM_REQ-1:0]           req_we_i,
  input  logic [NUM_REQ*ADDR_W-1:0]    req_addr_i,
  input  logic [NUM_REQ*4-1:0]         req_width_i,
  input  logic [NUM_REQ*DATA_W-1:0]    req_data_i,
  output logic [NUM_REQ-1:0]           req_ready_o,
  output logic [DATA_W-1:0]            req_data_o,
  output logic                         mem_ce_o,
  output logic                         mem_we_o,
  output logic [ADDR_W-1:0]            mem_addr_o,
  output logic [3:0]                   mem_width_o,
  output logic [DATA_W-1:0]            mem_data_o,
  input  logic [DATA_W-1:0]            mem_data_i,
  input  logic                         mem_ready_i,
  output logic [$clog2(NUM_REQ)-1:0]   grant_o,
  output logic                         busy_o,
  output logic                         timeout_err_o
);
  localparam int GW = $clog2(NUM_REQ);

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        width;
    logic [DATA_W-1:0] data;
  } req_t;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state, state_nxt;
  req_t          req_a [NUM_REQ];
  logic [GW-1:0] rr_ptr, pick, grant_inc;
  logic          pick_vld, tmo, done;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
    assign req_a[i] = '{we:    req_we_i[i],
                        addr:  req_addr_i[i*ADDR_W +: ADDR_W],
                        width: req_width_i[i*4 +: 4],
                        data:  req_data_i[i*DATA_W +: DATA_W]};
  end

  // first active requester at or above rr_ptr, wrapping
  always_comb begin
    int j;
    j        = 0;
    pick     = '0;
    pick_vld = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!pick_vld && req_ce_i[j]) begin
        pick_vld = 1'b1;
        pick     = GW'(j);
      end
    end
  end

  assign grant_inc = (grant_o == GW'(NUM_REQ-1)) ? '0 : grant_o + 1'b1;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES-1);
  logic [7:0] tmo_cnt;
  logic       tmo_err_q;
  assign tmo           = (state == BUSY) && !mem_ready_i && (tmo_cnt == TMO_LAST);
  assign timeout_err_o = tmo_err_q;
`else
  logic unused_tmo;
  assign unused_tmo    = ^TIMEOUT_CYCLES;
  assign tmo           = 1'b0;
  assign timeout_err_o = 1'b0;
`endif

  assign done = (state == BUSY) && (mem_ready_i || tmo);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (pick_vld) state_nxt = BUSY;
      BUSY: if (done)     state_nxt = IDLE;
      default:            state_nxt = IDLE;
    endcase
  end

  // completion strobe; an aborted access returns zero data
  always_comb begin
    req_ready_o = '0;
    req_data_o  = '0;
    if (done) begin
      req_ready_o[grant_o] = 1'b1;
      if (mem_ready_i) req_data_o = mem_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_ce_o    <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_width_o <= '0;
      mem_data_o  <= '0;
      grant_o     <= '0;
      rr_ptr      <= '0;
      busy_o      <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      tmo_cnt     <= '0;
      tmo_err_q   <= 1'b0;
`endif
    end else begin
`ifdef MEM_ARB_TIMEOUT_EN
      tmo_err_q <= tmo;
      tmo_cnt   <= (state == BUSY) ? tmo_cnt + 8'd1 : 8'd0;
`endif
      case (state)
        IDLE: if (pick_vld) begin
          grant_o     <= pick;
          mem_we_o    <= req_a[pick].we;
          mem_addr_o  <= req_a[pick].addr;
          mem_width_o <= req_a[pick].width;
          mem_data_o  <= req_a[pick].data;
          mem_ce_o    <= 1'b1;
          busy_o      <= 1'b1;
        end
        BUSY: if (done) begin
          mem_ce_o <= 1'b0;
          mem_we_o <= 1'b0;
          busy_o   <= 1'b0;
          rr_ptr   <= grant_inc;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: requester/memory models with an expected-transaction queue.
// Define MEM_ARB_TIMEOUT_EN to also exercise the BUSY watchdog (TIMEOUT_CYCLES = 8).
module tb_mem_arbiter;
  localparam int NR = 2, AW = 32, DW = 32, TO = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [NR-1:0]     req_ce_i, req_we_i, req_ready_o;
  logic [NR*AW-1:0]  req_addr_i;
  logic [NR*4-1:0]   req_width_i;
  logic [NR*DW-1:0]  req_data_i;
  logic [DW-1:0]     req_data_o, mem_data_o, mem_data_i;
  logic              mem_ce_o, mem_we_o, mem_ready_i, busy_o, timeout_err_o;
  logic [AW-1:0]     mem_addr_o;
  logic [3:0]        mem_width_o;
  logic [0:0]        grant_o;

  mem_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .req_ce_i(req_ce_i), .req_we_i(req_we_i), .req_addr_i(req_addr_i),
    .req_width_i(req_width_i), .req_data_i(req_data_i), .req_ready_o(req_ready_o),
    .req_data_o(req_data_o), .mem_ce_o(mem_ce_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_width_o(mem_width_o), .mem_data_o(mem_data_o), .mem_data_i(mem_data_i),
    .mem_ready_i(mem_ready_i), .grant_o(grant_o), .busy_o(busy_o), .timeout_err_o(timeout_err_o));

  typedef struct {
    int          idx;
    logic        we;
    logic [AW-1:0] addr;
    logic [3:0]  width;
    logic [DW-1:0] wdata;
    bit          tmo;
  } exp_t;

  exp_t          sb[$];
  int            vec = 0, errs = 0;
  int            lat = 3, bcnt = 0;
  bit            stray = 0, stray_act = 0, exp_terr = 0, chk_rst = 0;
  int            remain[NR];
  bit            rearm[NR];
  logic          c_we[NR];
  logic [AW-1:0] c_addr[NR];
  logic [3:0]    c_width[NR];
  logic [DW-1:0] c_data[NR];

  function automatic logic [DW-1:0] rd(logic [AW-1:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : {~a[15:0], a[15:0]};
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    vec++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic request(int i, logic we, logic [AW-1:0] a, logic [3:0] w, logic [DW-1:0] d, int n);
    c_we[i] = we; c_addr[i] = a; c_width[i] = w; c_data[i] = d;
    req_we_i[i]            = we;
    req_addr_i[i*AW +: AW] = a;
    req_width_i[i*4 +: 4]  = w;
    req_data_i[i*DW +: DW] = d;
    remain[i]   = n;
    req_ce_i[i] = 1'b1;
  endtask

  task automatic push(int i, bit tmo);
    exp_t e;
    e.idx = i; e.we = c_we[i]; e.addr = c_addr[i]; e.width = c_width[i]; e.wdata = c_data[i];
    e.tmo = tmo;
    sb.push_back(e);
  endtask

  // one clock: check at negedge, then update requester and memory models just after posedge
  task automatic tick();
    exp_t e;
    bit   done;
    int   di;
    done = 0; di = 0;
    @(negedge clk);
    if (!rst) begin
      chk("timeout_err", timeout_err_o, exp_terr);
      exp_terr = 0;
      if (chk_rst) begin
        chk("rst_ce", mem_ce_o, 0);      chk("rst_we", mem_we_o, 0);
        chk("rst_busy", busy_o, 0);      chk("rst_grant", grant_o, 0);
        chk("rst_addr", mem_addr_o, 0);  chk("rst_width", mem_width_o, 0);
        chk("rst_data", mem_data_o, 0);  chk("rst_ready", req_ready_o, 0);
        chk_rst = 0;
      end
      if (stray_act) begin
        chk("idle_ready_ignored", req_ready_o, 0);
        stray_act = 0;
      end
      if (busy_o === 1'b1 && sb.size() > 0) begin
        chk("busy_ce", mem_ce_o, 1);             chk("busy_addr", mem_addr_o, sb[0].addr);
        chk("busy_we", mem_we_o, sb[0].we);      chk("busy_width", mem_width_o, sb[0].width);
        chk("busy_wdata", mem_data_o, sb[0].wdata);
      end
      if (|req_ready_o) begin
        if (sb.size() == 0) begin
          chk("unexpected_ready", req_ready_o, 0);
        end else begin
          e = sb.pop_front();
          chk("ready_onehot", req_ready_o, 64'(1) << e.idx);
          chk("grant", grant_o, e.idx);
          chk("rdata", req_data_o, e.tmo ? 0 : rd(e.addr));
          chk("latency", bcnt, e.tmo ? TO : lat);
          if (e.tmo) exp_terr = 1;
          done = 1; di = e.idx;
        end
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++)
      if (rearm[i] && !(done && di == i)) begin
        rearm[i] = 0;
        if (remain[i] > 0) req_ce_i[i] = 1'b1;
      end
    if (done) begin
      remain[di]   = remain[di] - 1;
      req_ce_i[di] = 1'b0;
      rearm[di]    = 1;
    end
    bcnt        = (mem_ce_o === 1'b1) ? bcnt + 1 : 0;
    mem_ready_i = ((mem_ce_o === 1'b1) && bcnt == lat) || stray;
    mem_data_i  = rd(mem_addr_o);
    stray_act   = stray;
    stray       = 0;
  endtask

  task automatic drain(string tag);
    int k;
    k = 0;
    while (sb.size() > 0 && k < 300) begin tick(); k++; end
    if (sb.size() > 0) begin
      vec++; errs++;
      $display("FAIL %s: %0d transactions outstanding, required 0", tag, sb.size());
      sb.delete();
      req_ce_i = '0;
    end
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_ce_i = '0;
    for (int i = 0; i < NR; i++) begin remain[i] = 0; rearm[i] = 0; end
    tick(); tick();
    rst = 1'b0;
    chk_rst = 1;
    tick();
  endtask

  initial begin
    rst = 1'b1; req_ce_i = '0; req_we_i = '0; req_addr_i = '0; req_width_i = '0;
    req_data_i = '0; mem_data_i = '0; mem_ready_i = 1'b0;
    do_reset();

    // single read
    request(0, 1'b0, 32'h100, 4'd4, 32'h0, 1); push(0, 0);
    drain("single_read");

    // simultaneous requests after reset: requester 0 first
    do_reset();
    request(0, 1'b0, 32'h200, 4'd4, 32'h0, 1);
    request(1, 1'b0, 32'h204, 4'd2, 32'h0, 1);
    push(0, 0); push(1, 0);
    drain("contention");

    // continuous re-requests rotate 0,1,0,1,0,1
    lat = 2;
    request(0, 1'b0, 32'h310, 4'd1, 32'h0, 3);
    request(1, 1'b0, 32'h320, 4'd4, 32'h0, 3);
    for (int n = 0; n < 3; n++) begin push(0, 0); push(1, 0); end
    drain("rotation");

    // write; later input changes must not reach the memory port
    lat = 4;
    request(1, 1'b1, 32'h20, 4'd4, 32'h12345678, 1); push(1, 0);
    tick(); tick();
    req_data_i[DW +: DW] = 32'hCAFEF00D;
    req_addr_i[AW +: AW] = 32'h9999;
    drain("write");

    // stray memory ready while idle
    stray = 1;
    tick(); tick();

    // reset mid-BUSY, then the still-pending requester is served
    lat = 1000;
    request(1, 1'b0, 32'h44, 4'd2, 32'h0, 1); push(1, 0);
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_rst = 1;
    lat = 3;
    drain("reset_mid_busy");

`ifdef MEM_ARB_TIMEOUT_EN
    do_reset();
    lat = 1000;
    request(0, 1'b0, 32'h300, 4'd4, 32'h0, 1);
    request(1, 1'b0, 32'h304, 4'd4, 32'h0, 1);
    push(0, 1); push(1, 1);
    drain("timeout");
    lat = 3;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
